// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sweep_pkg
// Description : Shared types and sizing helpers for the truth-table sweeper
//               and related stimulus engines.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest supported stimulus width
  localparam int MAX_N_IN = 10;

  // Number of input vectors for an n-input block
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

  // Error counter width: must hold the value 2**n_in (every vector failing)
  function automatic int err_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Counts 0..HOLD-1 while enabled and flags the last count.
//               Held at zero while clr is high.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
  parameter int HOLD = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(HOLD - 1);

  logic [CW-1:0] count;

  // Free-running modulo-HOLD counter, parked at zero while cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == C_LAST) count <= '0;
      else                 count <= count + 1'b1;
    end
  end

  assign last = en && (count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input vector of a combinational block in
//               ascending order, holds each for HOLD cycles, samples the
//               block output on the last hold cycle and compares it with the
//               expected truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                     N_IN   = 4,
  parameter int                     HOLD   = 5,
  parameter logic [(1<<N_IN)-1:0]   EXP_TT = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             vec_out,
  input  logic                        dut_y,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [err_w(N_IN)-1:0]      err_count,
  output logic [N_IN-1:0]             first_err_idx,
  output logic                        first_err_vld,
  output logic [(1<<N_IN)-1:0]        tt_cap
);

  localparam int              NVEC   = nvec(N_IN);
  localparam int              EW     = err_w(N_IN);
  localparam logic [N_IN-1:0] C_VMAX = N_IN'(NVEC - 1);

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic            launch;
  logic            sample;
  logic            final_vec;
  logic            mismatch;
  logic [EW-1:0]   err_nxt;
  logic            pass_r;

  // A start is honoured only outside APPLY; abort wins over a same-cycle sample
  assign launch    = start && ((state == IDLE) || (state == DONE));
  assign sample    = (state == APPLY) && last && !abort;
  assign final_vec = (vec_out == C_VMAX);
  assign mismatch  = (dut_y != EXP_TT[vec_out]);
  assign err_nxt   = err_count + EW'(mismatch);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != APPLY),
    .en   (state == APPLY),
    .last (last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY: begin
        if (abort)                    state_nxt = IDLE;
        else if (sample && final_vec) state_nxt = DONE;
      end
      DONE:    if (start) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      tt_cap        <= '0;
      pass_r        <= 1'b0;
    end else if (launch) begin
      vec_out       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      tt_cap        <= '0;
      pass_r        <= 1'b0;
    end else if (state == APPLY) begin
      if (abort) begin
        // Partial results are kept for inspection; only the stimulus rewinds
        vec_out <= '0;
      end else if (sample) begin
        tt_cap[vec_out] <= dut_y;
        err_count       <= err_nxt;
        if (mismatch && !first_err_vld) begin
          first_err_idx <= vec_out;
          first_err_vld <= 1'b1;
        end
        if (final_vec) pass_r  <= (err_nxt == '0);
        else           vec_out <= vec_out + 1'b1;
      end
    end
  end

  assign busy = (state == APPLY);
  assign done = (state == DONE);
  assign pass = pass_r;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed self-checking bench for truth_table_sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4-input, HOLD=5 instance
  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic [3:0]  vec4;
  logic        y4;
  logic        busy4, done4, pass4, fvld4;
  logic [4:0]  err4;
  logic [3:0]  fidx4;
  logic [15:0] tt4;

  // 2-input, HOLD=1 XOR instance
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [1:0]  vec2;
  logic        y2;
  logic        busy2, done2, pass2, fvld2;
  logic [2:0]  err2;
  logic [1:0]  fidx2;
  logic [3:0]  tt2;

  // Block-under-test model: 0 = correct, 1 = vectors 5 and 12 flipped, 2 = tied low
  logic [1:0]  mode = 2'd0;
  logic [15:0] exp_tt = 16'hA5C3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign y4 = (mode == 2'd2) ? 1'b0
            : (exp_tt[vec4] ^ ((mode == 2'd1) && ((vec4 == 4'd5) || (vec4 == 4'd12))));
  assign y2 = vec2[1] ^ vec2[0];

  truth_table_sweeper #(
    .N_IN   (4),
    .HOLD   (5),
    .EXP_TT (16'hA5C3)
  ) dut4 (
    .clk           (clk),
    .rst           (rst),
    .start         (start4),
    .abort         (abort4),
    .vec_out       (vec4),
    .dut_y         (y4),
    .busy          (busy4),
    .done          (done4),
    .pass          (pass4),
    .err_count     (err4),
    .first_err_idx (fidx4),
    .first_err_vld (fvld4),
    .tt_cap        (tt4)
  );

  truth_table_sweeper #(
    .N_IN   (2),
    .HOLD   (1),
    .EXP_TT (4'b0110)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .start         (start2),
    .abort         (abort2),
    .vec_out       (vec2),
    .dut_y         (y2),
    .busy          (busy2),
    .done          (done2),
    .pass          (pass2),
    .err_count     (err2),
    .first_err_idx (fidx2),
    .first_err_vld (fvld2),
    .tt_cap        (tt2)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic        fvld;
    logic        pass;
    logic [15:0] tt;
  } sweep_vec_t;

  sweep_vec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulse start on the 4-input instance and count edges until done (bounded)
  task automatic run_sweep4(output int cycles, input bit poke_start);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    cycles = 0;
    while (!done4 && cycles < 400) begin
      @(posedge clk);
      #1 cycles++;
      start4 = poke_start && (cycles == 20);
    end
    start4 = 1'b0;
  endtask

  initial begin
    int cyc;

    tbl[0] = '{mode: 2'd0, err: 5'd0, fidx: 4'd0, fvld: 1'b0, pass: 1'b1, tt: 16'hA5C3};
    tbl[1] = '{mode: 2'd1, err: 5'd2, fidx: 4'd5, fvld: 1'b1, pass: 1'b0, tt: 16'hB5E3};
    tbl[2] = '{mode: 2'd2, err: 5'd8, fidx: 4'd0, fvld: 1'b1, pass: 1'b0, tt: 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec",  32'(vec4),  32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_pass", 32'(pass4), 32'd0);
    check("rst_tt",   32'(tt4),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweeps from the table; later entries re-run from DONE
    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      run_sweep4(cyc, 1'b0);
      check($sformatf("t%0d_cycles", i), 32'(cyc),   32'd80);
      check($sformatf("t%0d_done", i),   32'(done4), 32'd1);
      check($sformatf("t%0d_busy", i),   32'(busy4), 32'd0);
      check($sformatf("t%0d_pass", i),   32'(pass4), 32'(tbl[i].pass));
      check($sformatf("t%0d_err", i),    32'(err4),  32'(tbl[i].err));
      check($sformatf("t%0d_fidx", i),   32'(fidx4), 32'(tbl[i].fidx));
      check($sformatf("t%0d_fvld", i),   32'(fvld4), 32'(tbl[i].fvld));
      check($sformatf("t%0d_tt", i),     32'(tt4),   32'(tbl[i].tt));
      check($sformatf("t%0d_vec", i),    32'(vec4),  32'd15);
    end

    // Abort exactly on the sampling edge of vector 5 (flipped model): sample dropped
    mode = 2'd1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("ab_pre_vec", 32'(vec4), 32'd5);
    abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    check("ab_busy", 32'(busy4), 32'd0);
    check("ab_done", 32'(done4), 32'd0);
    check("ab_vec",  32'(vec4),  32'd0);
    check("ab_err",  32'(err4),  32'd0);
    check("ab_fvld", 32'(fvld4), 32'd0);
    check("ab_tt",   32'(tt4),   32'h0003);
    repeat (3) @(posedge clk);
    #1;
    check("ab_idle_busy", 32'(busy4), 32'd0);

    // Fresh sweep after abort, with a stray start mid-sweep
    mode = 2'd0;
    run_sweep4(cyc, 1'b1);
    check("ab2_cycles", 32'(cyc),   32'd80);
    check("ab2_pass",   32'(pass4), 32'd1);
    check("ab2_tt",     32'(tt4),   32'hA5C3);

    // Asynchronous reset mid-sweep
    mode = 2'd1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("ar_pre_err", 32'(err4), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_vec",  32'(vec4),  32'd0);
    check("ar_busy", 32'(busy4), 32'd0);
    check("ar_done", 32'(done4), 32'd0);
    check("ar_pass", 32'(pass4), 32'd0);
    check("ar_err",  32'(err4),  32'd0);
    check("ar_fidx", 32'(fidx4), 32'd0);
    check("ar_fvld", 32'(fvld4), 32'd0);
    check("ar_tt",   32'(tt4),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ar_stay_busy", 32'(busy4), 32'd0);
    check("ar_stay_vec",  32'(vec4),  32'd0);
    mode = 2'd0;
    run_sweep4(cyc, 1'b0);
    check("ar2_cycles", 32'(cyc),   32'd80);
    check("ar2_pass",   32'(pass4), 32'd1);

    // 2-input XOR, HOLD=1: one vector per cycle
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      check($sformatf("x_vec%0d", v),  32'(vec2),  32'(v));
      check($sformatf("x_busy%0d", v), 32'(busy2), 32'd1);
      @(posedge clk);
      #1;
    end
    check("x_done", 32'(done2), 32'd1);
    check("x_pass", 32'(pass2), 32'd1);
    check("x_err",  32'(err2),  32'd0);
    check("x_tt",   32'(tt2),   32'h6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
